// File: rtl/mips_mem_arbiter.sv
// Purpose : share one single-port memory bus between the fetch and data ports of a Harvard MIPS core.
// Latency : 3 clocks per non-memory instruction and 4 per load/store at zero wait; each waitrequest cycle adds one.
// Backpressure: strobes are held while mem_waitrequest is high, and dropped (bus_timeout set) after MAX_WAIT waits.
// Optional: define MEM_ARB_STATS_EN to add the stall_count / instr_count statistics outputs.
module mips_mem_arbiter #(
    parameter int MAX_WAIT = 1023
) (
    input  logic        clk,
    input  logic        reset,
    output logic        clk_enable,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata,
`ifdef MEM_ARB_STATS_EN
    output logic [31:0] stall_count,
    output logic [31:0] instr_count,
`endif
    output logic        bus_timeout,
    output logic        protocol_error
);

    localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

    // S_DECODE is the cycle after the fetch is accepted: the CPU decodes the
    // freshly registered instruction and drives data_read/data_write from it.
    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_DATA   = 2'd2,
        S_READY  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic [31:0]   instr_q, instr_d;
    logic [31:0]   data_q, data_d;
    logic          tout_q, tout_d;
    logic          perr_q, perr_d;

    // State register and captured data; synchronous reset aborts any access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
            instr_q <= '0;
            data_q  <= '0;
            tout_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            instr_q <= instr_d;
            data_q  <= data_d;
            tout_q  <= tout_d;
            perr_q  <= perr_d;
        end
    end

    // Next-state, wait counting, data capture and sticky error flags.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        instr_d = instr_q;
        data_d  = data_q;
        tout_d  = tout_q;
        perr_d  = perr_q;
        unique case (state_q)
            S_FETCH: begin
                if (!mem_waitrequest) begin
                    instr_d = mem_readdata;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    tout_d  = 1'b1;
                    state_d = S_READY;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            S_DECODE: begin
                state_d = (data_read || data_write) ? S_DATA : S_READY;
            end
            S_DATA: begin
                // Conflicting request: the store is issued, the load is dropped.
                if (data_read && data_write) begin
                    perr_d = 1'b1;
                end
                if (!mem_waitrequest) begin
                    if (data_read && !data_write) begin
                        data_d = mem_readdata;
                    end
                    state_d = S_READY;
                end else if (wait_q == WAIT_LAST) begin
                    tout_d  = 1'b1;
                    state_d = S_READY;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            S_READY: begin
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
        // The wait budget is per access, so any state change restarts it.
        if (state_d != state_q) begin
            wait_d = '0;
        end
    end

    // Bus strobes and the CPU advance pulse, all forced low while in reset.
    always_comb begin
        mem_address   = instr_address;
        mem_writedata = data_writedata;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        clk_enable    = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem_read = !reset;
            end
            S_DATA: begin
                mem_address = data_address;
                if (data_write) begin
                    mem_write = !reset;
                end else if (data_read) begin
                    mem_read = !reset;
                end
            end
            S_READY: begin
                clk_enable = !reset;
            end
            default: begin
                mem_read = 1'b0;
            end
        endcase
    end

    assign instr_readdata = instr_q;
    assign data_readdata  = data_q;
    assign bus_timeout    = tout_q;
    assign protocol_error = perr_q;

`ifdef MEM_ARB_STATS_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] icnt_q, icnt_d;

    // Free-running statistics; both wrap naturally at 2^32.
    always_comb begin
        stall_d = stall_q;
        icnt_d  = icnt_q;
        if (clk_enable) begin
            icnt_d = icnt_q + 32'd1;
        end else begin
            stall_d = stall_q + 32'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            icnt_q  <= '0;
        end else begin
            stall_q <= stall_d;
            icnt_q  <= icnt_d;
        end
    end

    assign stall_count = stall_q;
    assign instr_count = icnt_q;
`endif

endmodule

// File: tb/tb_mips_mem_arbiter.sv
module tb_mips_mem_arbiter;

    localparam int M = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk_enable;
    logic [31:0] instr_address = '0;
    logic [31:0] instr_readdata;
    logic [31:0] data_address = '0;
    logic        data_read = 1'b0;
    logic        data_write = 1'b0;
    logic [31:0] data_writedata = '0;
    logic [31:0] data_readdata;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        mem_waitrequest = 1'b1;
    logic [31:0] mem_readdata = '0;
    logic        bus_timeout;
    logic        protocol_error;
`ifdef MEM_ARB_STATS_EN
    logic [31:0] stall_count;
    logic [31:0] instr_count;
`endif

    int tests = 0;
    int fails = 0;

    // Reference state: what the CPU-visible registers should hold.
    logic [31:0] m_instr = '0;
    logic [31:0] m_data  = '0;
    logic        m_tout  = 1'b0;
    logic        m_perr  = 1'b0;

    mips_mem_arbiter #(.MAX_WAIT(M)) dut (
        .clk            (clk),
        .reset          (reset),
        .clk_enable     (clk_enable),
        .instr_address  (instr_address),
        .instr_readdata (instr_readdata),
        .data_address   (data_address),
        .data_read      (data_read),
        .data_write     (data_write),
        .data_writedata (data_writedata),
        .data_readdata  (data_readdata),
        .mem_address    (mem_address),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_waitrequest(mem_waitrequest),
        .mem_readdata   (mem_readdata),
`ifdef MEM_ARB_STATS_EN
        .stall_count    (stall_count),
        .instr_count    (instr_count),
`endif
        .bus_timeout    (bus_timeout),
        .protocol_error (protocol_error)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One CPU instruction: fw/dw are the waitrequest cycles the slave inserts
    // on the fetch and on the data access. Starts on the first FETCH cycle.
    task automatic run_txn(input string nm, input logic [31:0] ia, input logic [31:0] instr,
                           input logic rd, input logic wr, input logic [31:0] da,
                           input logic [31:0] wd, input logic [31:0] rdat,
                           input int fw, input int dw);
        int acc = 0, used = 0, ce_cyc = -1, rd_cnt = 0, wr_cnt = 0, bad_wr = 0, overlap = 0;
        logic first_ok = 1'b0;
        logic ftime, has, dtime;
        int exp_cyc, exp_rd, exp_wr, fcyc, dcyc;
        @(negedge clk);
        instr_address  = ia;
        data_read      = rd;
        data_write     = wr;
        data_address   = da;
        data_writedata = wd;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) @(negedge clk);
            mem_waitrequest = (used < ((acc == 0) ? fw : dw));
            mem_readdata    = (acc == 0) ? instr : rdat;
            #1;
            if (c == 1) first_ok = mem_read && !mem_write && !clk_enable && (mem_address == ia);
            if (mem_read && mem_write) overlap++;
            if (clk_enable && (mem_read || mem_write)) overlap++;
            if (mem_read) rd_cnt++;
            if (mem_write) begin
                wr_cnt++;
                if (mem_address !== da || mem_writedata !== wd) bad_wr++;
            end
            if (clk_enable) begin
                ce_cyc = c;
                break;
            end
            if (mem_read || mem_write) begin
                if (mem_waitrequest) used++;
                else begin
                    acc++;
                    used = 0;
                end
            end
        end
        // Expected behaviour derived from cycle budgets per phase.
        ftime   = (fw >= M);
        has     = rd || wr;
        dtime   = has && !ftime && (dw >= M);
        fcyc    = ftime ? M : fw + 1;
        dcyc    = dtime ? M : dw + 1;
        exp_cyc = ftime ? M + 1 : fcyc + 1 + (has ? dcyc : 0) + 1;
        exp_rd  = fcyc + ((!ftime && rd && !wr) ? dcyc : 0);
        exp_wr  = (!ftime && wr) ? dcyc : 0;
        if (!ftime) m_instr = instr;
        if (!ftime && rd && !wr && !dtime) m_data = rdat;
        if (ftime || dtime) m_tout = 1'b1;
        if (!ftime && rd && wr) m_perr = 1'b1;

        tests++;
        if (first_ok !== 1'b1) begin
            fails++;
            $display("FAIL %s first_fetch: mem_read/addr/clk_enable wrong on cycle 1, want read of %h", nm, ia);
        end
        tests++;
        if (ce_cyc !== exp_cyc) begin
            fails++;
            $display("FAIL %s clk_enable_cycle: got %0d want %0d", nm, ce_cyc, exp_cyc);
        end
        tests++;
        if (instr_readdata !== m_instr) begin
            fails++;
            $display("FAIL %s instr_readdata: got %h want %h", nm, instr_readdata, m_instr);
        end
        tests++;
        if (data_readdata !== m_data) begin
            fails++;
            $display("FAIL %s data_readdata: got %h want %h", nm, data_readdata, m_data);
        end
        tests++;
        if (bus_timeout !== m_tout || protocol_error !== m_perr) begin
            fails++;
            $display("FAIL %s flags: got tout=%b perr=%b want tout=%b perr=%b",
                     nm, bus_timeout, protocol_error, m_tout, m_perr);
        end
        tests++;
        if (rd_cnt !== exp_rd || wr_cnt !== exp_wr) begin
            fails++;
            $display("FAIL %s strobe_cycles: got rd=%0d wr=%0d want rd=%0d wr=%0d",
                     nm, rd_cnt, wr_cnt, exp_rd, exp_wr);
        end
        tests++;
        if (overlap !== 0 || bad_wr !== 0) begin
            fails++;
            $display("FAIL %s bus_rules: got overlap=%0d bad_write=%0d want 0 0", nm, overlap, bad_wr);
        end
    endtask

    // Hold reset several cycles; strobes low during it, registers zero after.
    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        mem_waitrequest = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        tests++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0 || clk_enable !== 1'b0) begin
            fails++;
            $display("FAIL reset_strobes: got rd=%b wr=%b ce=%b want 0 0 0", mem_read, mem_write, clk_enable);
        end
        @(posedge clk);
        #1;
        tests++;
        if (instr_readdata !== 32'h0 || data_readdata !== 32'h0 || bus_timeout !== 1'b0
            || protocol_error !== 1'b0) begin
            fails++;
            $display("FAIL reset_regs: got i=%h d=%h tout=%b perr=%b want all zero",
                     instr_readdata, data_readdata, bus_timeout, protocol_error);
        end
        reset   = 1'b0;
        m_instr = '0;
        m_data  = '0;
        m_tout  = 1'b0;
        m_perr  = 1'b0;
    endtask

    task automatic test_zero_wait_fetch();
        run_txn("zero_wait_fetch", 32'hBFC0_0000, 32'h2401_0020, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 0);
    endtask

    task automatic test_load_waits();
        run_txn("load_2_waits", 32'hBFC0_0004, 32'h8C22_0000, 1'b1, 1'b0, 32'h10, 32'h0, 32'hF000_0000, 0, 2);
    endtask

    task automatic test_store();
        run_txn("store", 32'hBFC0_0008, 32'hAC22_0020, 1'b0, 1'b1, 32'h20, 32'hDEAD_BEEF, 32'h1234_5678, 0, 0);
    endtask

    // Write wins on a conflict; protocol_error must stay set over later instructions.
    task automatic test_conflict();
        run_txn("conflict", 32'hBFC0_000C, 32'hAC22_0030, 1'b1, 1'b1, 32'h30, 32'hCAFE_F00D, 32'h5555_AAAA, 0, 1);
        run_txn("conflict_sticky", 32'hBFC0_0010, 32'h0000_0000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1, 0);
    endtask

    // Fetch stuck in wait: aborted after M waits, then the next fetch works.
    task automatic test_timeout();
        run_txn("fetch_timeout", 32'hBFC0_0014, 32'h1111_1111, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 9, 0);
        run_txn("after_timeout", 32'hBFC0_0018, 32'h2222_2222, 1'b1, 1'b0, 32'h40, 32'h0, 32'h3333_3333, 0, M - 1);
        run_txn("data_timeout", 32'hBFC0_001C, 32'h8C22_0044, 1'b1, 1'b0, 32'h44, 32'h0, 32'h4444_4444, 0, M);
    endtask

    // Reset in the middle of a 3-wait load: no pulse, buffers cleared.
    task automatic test_reset_mid_data();
        @(negedge clk);
        instr_address = 32'hBFC0_0100;
        data_read = 1'b1;
        data_write = 1'b0;
        data_address = 32'h80;
        mem_waitrequest = 1'b0;
        mem_readdata = 32'h8C22_0080;
        @(negedge clk);
        mem_waitrequest = 1'b1;
        @(negedge clk);
        #1;
        tests++;
        if (mem_read !== 1'b1 || mem_address !== 32'h80) begin
            fails++;
            $display("FAIL mid_data_setup: got rd=%b addr=%h want 1 00000080", mem_read, mem_address);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        tests++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0 || clk_enable !== 1'b0) begin
            fails++;
            $display("FAIL mid_data_reset_strobes: got rd=%b wr=%b ce=%b want 0 0 0",
                     mem_read, mem_write, clk_enable);
        end
        @(posedge clk);
        #1;
        tests++;
        if (data_readdata !== 32'h0 || instr_readdata !== 32'h0) begin
            fails++;
            $display("FAIL mid_data_reset_regs: got i=%h d=%h want 0 0", instr_readdata, data_readdata);
        end
        reset   = 1'b0;
        m_instr = '0;
        m_data  = '0;
        m_tout  = 1'b0;
        m_perr  = 1'b0;
        run_txn("after_mid_reset", 32'hBFC0_0104, 32'h8C22_0084, 1'b1, 1'b0, 32'h84, 32'h0, 32'h7777_0000, 0, 3);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            int kind;
            logic rd, wr;
            kind = $urandom_range(0, 7);
            rd = (kind == 1 || kind == 2 || kind == 7);
            wr = (kind == 3 || kind == 4 || kind == 7);
            run_txn("random", $urandom, $urandom, rd, wr, $urandom, $urandom, $urandom,
                    $urandom_range(0, 5), $urandom_range(0, 5));
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait_fetch();
        test_load_waits();
        test_store();
        test_conflict();
        test_timeout();
        test_reset();
        test_reset_mid_data();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
